boot_loader: RTL
================

Name: boot_loader

Overview:
- Parametrised successor to the single-purpose bootstrapper.
- At power-up it copies TARGETS contiguous images from a byte-wide EEPROM into TARGETS separate SRAMs, such as the MLU slice, MLU lookahead and microcode stores.
- It verifies an additive checksum over all copied bytes, then releases the rest of the CPU by driving N_BOOTED low.
- It can be re-run without a reset by pulsing REBOOT.

Parameters:
TARGETS, 3, number of destination SRAMs (1..8)
DEPTH, 4096, bytes per target image (1..2**ADDR_W)
ADDR_W, 12, SRAM address width
DATA_W, 8, data width; checksum is computed modulo 2**DATA_W
ROM_LAT, 2, EEPROM read latency in CLK cycles (>=1)
ROM_AW, derived, $clog2(TARGETS*DEPTH+1), EEPROM address width (localparam)

Ports:
CLK  in  1  system clock, rising edge
N_RST  in  1  asynchronous active-low reset
REBOOT  in  1  synchronous restart request; honoured only in DONE
ROM_ADDR  out  ROM_AW  EEPROM byte address
ROM_DATA  in  DATA_W  EEPROM data, valid ROM_LAT cycles after ROM_ADDR changes
ADDR  out  ADDR_W  SRAM address (offset within current target)
DATA  out  DATA_W  SRAM write data
N_WE  out  TARGETS  one-hot-low SRAM write strobes, bit t selects target t
N_BOOTED  out  1  1 while loading; 0 once loading and checksum are complete
ERR  out  1  1 in DONE if the checksum mismatched

Behaviour:
- Interface: one clock (CLK); reset N_RST is asynchronous and active-low.
- Reset (asynchronous, immediate):
  - Outputs: ROM_ADDR=0, ADDR=0, DATA=0, N_WE=all 1, N_BOOTED=1, ERR=0.
  - Internal: state=FETCH, wait counter=0, target=0, offset=0, sum=0.
  - Reset asserted mid-strobe must raise N_WE combinationally-free, i.e. directly from the reset flop. No partial write survives.
- EEPROM layout: byte of target t at offset o lives at ROM address t*DEPTH+o. The checksum byte lives at TARGETS*DEPTH.
- Counters: target and offset are separate counters (no divider). Offset wraps to 0 and target increments after offset DEPTH-1.
- States:
  - FETCH:
    - ROM_ADDR = t*DEPTH+o.
    - Wait ROM_LAT cycles.
    - On the last wait edge: capture ROM_DATA into the data register, add it to sum (mod 2**DATA_W), go to SETUP.
  - SETUP: ADDR=o, DATA=captured byte, N_WE all 1. Next state STROBE.
  - STROBE: N_WE[t]=0, all other bits 1. ADDR/DATA unchanged. Next state HOLD.
  - HOLD:
    - N_WE all 1; ADDR/DATA unchanged.
    - If this was the last byte (t=TARGETS-1, o=DEPTH-1), go to CHECK.
    - Otherwise advance o/t and go to FETCH.
  - CHECK:
    - ROM_ADDR = TARGETS*DEPTH.
    - Wait ROM_LAT cycles.
    - On the last edge: ERR <= (ROM_DATA != sum), N_BOOTED <= 0, go to DONE.
  - DONE:
    - Terminal; outputs held; N_WE all 1.
    - REBOOT=1 on an edge clears sum, t, o, ERR and the wait counter, sets N_BOOTED=1, and goes to FETCH.
- REBOOT in any state other than DONE is ignored.
- Timing:
  - Each byte takes exactly ROM_LAT+3 edges.
  - ROM_ADDR changes only on entry to FETCH or CHECK.
  - ADDR/DATA are stable from SETUP through HOLD, bracketing the strobe by one cycle on each side.
  - With edge 1 being the first rising edge after N_RST deasserts, N_BOOTED falls on edge K = TARGETS*DEPTH*(ROM_LAT+3)+ROM_LAT.
- Invariants:
  - At most one N_WE bit is ever low.
  - N_WE is never low outside STROBE.
  - N_BOOTED=0 implies all N_WE are 1.
- Edge parameters:
  - DEPTH=1: every byte is the last of its target.
  - TARGETS=1: no target advance occurs.

Test Plan:
1. TARGETS=2, DEPTH=4, ROM_LAT=2; ROM bytes 0..7 = 0x10..0x17, ROM[8]=0x9C.
   - SRAM0 = 10,11,12,13 and SRAM1 = 14,15,16,17.
   - N_BOOTED falls on edge 42 with ERR=0.
   - Exactly 8 strobes occur, each one cycle wide with ADDR/DATA stable ±1 cycle.
2. Same image with ROM[8]=0x9D: all 8 writes still performed; on edge 42 N_BOOTED=0 and ERR=1.
3. Assert N_RST during the STROBE of byte 5 (target 1, offset 1):
   - N_WE returns to all-1 immediately and all outputs take their reset values.
   - After release the full sequence restarts from ROM_ADDR 0 and completes on edge 42.
4. REBOOT=1 held during loading: no effect, N_BOOTED still falls on edge 42.
   - REBOOT=1 for one edge in DONE: N_BOOTED=1 and ERR=0 next cycle; reload from address 0 completes 42 edges later.
5. Change ROM byte 3 to 0xFF before the REBOOT of scenario 4's second run: SRAM0[3]=0xFF and ERR=1 at completion.
6. TARGETS=3, DEPTH=1, ROM_LAT=1; ROM = A5,5A,FF,FE:
   - One write per target: N_WE bit 0, then bit 1, then bit 2, each with ADDR=0.
   - N_BOOTED falls on edge 13 with ERR=0.

Source files
------------

// File: rtl/boot_loader_if.sv
// rtl/boot_loader_if.sv - EEPROM/SRAM boot bus between the loader and its memories
interface boot_loader_if #(
  parameter int TARGETS = 3,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int ROM_AW  = 14
);
  logic                reboot;
  logic [ROM_AW-1:0]   rom_addr;
  logic [DATA_W-1:0]   rom_data;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   data;
  logic [TARGETS-1:0]  n_we;
  logic                n_booted;
  logic                err;

  modport master (
    input  reboot, rom_data,
    output rom_addr, addr, data, n_we, n_booted, err
  );

  modport slave (
    output reboot, rom_data,
    input  rom_addr, addr, data, n_we, n_booted, err
  );
endinterface

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - copies TARGETS EEPROM images into SRAMs and verifies an additive checksum
module boot_loader #(
  parameter int TARGETS = 3,
  parameter int DEPTH   = 4096,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 2
) (
  input  logic          clk,
  input  logic          n_rst,
  boot_loader_if.master bus
);
  localparam int ROM_AW = $clog2(TARGETS*DEPTH+1);
  localparam int WAIT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam int TGT_W  = (TARGETS > 1) ? $clog2(TARGETS) : 1;

  localparam logic [WAIT_W-1:0] LAT_LAST = WAIT_W'(ROM_LAT-1);
  localparam logic [TGT_W-1:0]  TGT_LAST = TGT_W'(TARGETS-1);
  localparam logic [ADDR_W-1:0] OFF_LAST = ADDR_W'(DEPTH-1);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] STROBE = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] CHECK  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0]         state;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [TGT_W-1:0]   tgt;
  logic [ADDR_W-1:0]  off;
  logic [DATA_W-1:0]  sum;
  logic [ROM_AW-1:0]  rom_addr_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [DATA_W-1:0]  data_r;
  logic [TARGETS-1:0] n_we_r;
  logic               n_booted_r;
  logic               err_r;

  // Images are contiguous and the checksum byte follows the last image,
  // so the ROM address simply steps by one after every HOLD.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= FETCH;
      wait_cnt   <= '0;
      tgt        <= '0;
      off        <= '0;
      sum        <= '0;
      rom_addr_r <= '0;
      addr_r     <= '0;
      data_r     <= '0;
      n_we_r     <= '1;
      n_booted_r <= 1'b1;
      err_r      <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (wait_cnt == LAT_LAST) begin
            wait_cnt <= '0;
            data_r   <= bus.rom_data;
            addr_r   <= off;
            sum      <= sum + bus.rom_data;
            state    <= SETUP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        SETUP: begin
          n_we_r <= ~(TARGETS'(1) << tgt);
          state  <= STROBE;
        end
        STROBE: begin
          n_we_r <= '1;
          state  <= HOLD;
        end
        HOLD: begin
          rom_addr_r <= rom_addr_r + 1'b1;
          if (off == OFF_LAST) begin
            off <= '0;
            if (tgt == TGT_LAST) begin
              state <= CHECK;
            end else begin
              tgt   <= tgt + 1'b1;
              state <= FETCH;
            end
          end else begin
            off   <= off + 1'b1;
            state <= FETCH;
          end
        end
        CHECK: begin
          if (wait_cnt == LAT_LAST) begin
            wait_cnt   <= '0;
            err_r      <= (bus.rom_data != sum);
            n_booted_r <= 1'b0;
            state      <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.reboot) begin
            wait_cnt   <= '0;
            tgt        <= '0;
            off        <= '0;
            sum        <= '0;
            rom_addr_r <= '0;
            err_r      <= 1'b0;
            n_booted_r <= 1'b1;
            state      <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign bus.rom_addr = rom_addr_r;
  assign bus.addr     = addr_r;
  assign bus.data     = data_r;
  assign bus.n_we     = n_we_r;
  assign bus.n_booted = n_booted_r;
  assign bus.err      = err_r;
endmodule
